// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle control sequencer: opcodes, FSM states,
// instruction classes and IR field positions.
package ctrl_pkg;
  localparam int CTRL_DATA_W = 16;
  localparam int CTRL_ADR_W  = 3;
  localparam int CTRL_OP_W   = 4;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_MOV = 4'h6;
  localparam logic [3:0] OP_INC = 4'h7;
  localparam logic [3:0] OP_LD  = 4'h8;
  localparam logic [3:0] OP_ST  = 4'h9;
  localparam logic [3:0] OP_BRZ = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  // ALU function select reuses the opcode value; 0 means "no ALU op"
  localparam logic [3:0] ALU_NONE = 4'h0;

  localparam int IR_OP_LSB = 12;
  localparam int IR_W_LSB  = 6;
  localparam int IR_R_LSB  = 3;
  localparam int IR_S_LSB  = 0;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT} state_t;
  typedef enum logic [2:0] {CL_NOP, CL_ALU, CL_LD, CL_ST, CL_BRZ, CL_HLT, CL_ILL} iclass_t;
endpackage

// File: rtl/control_sequencer_if.sv
// Memory/ALU/register-file control bus between the sequencer (master) and the datapath (slave).
interface control_sequencer_if;
  import ctrl_pkg::*;
  logic [CTRL_DATA_W-1:0] instr;
  logic                   mem_rdy;
  logic                   zflag;
  logic                   ir_ld;
  logic                   pc_inc;
  logic                   pc_ld;
  logic                   mem_rd;
  logic                   mem_wr;
  logic [CTRL_OP_W-1:0]   alu_op;
  logic                   w_sel;
  logic [CTRL_ADR_W-1:0]  W_Adr;
  logic                   we;
  logic [CTRL_ADR_W-1:0]  R_Adr;
  logic [CTRL_ADR_W-1:0]  S_Adr;
  logic                   halted;
  logic                   illegal;

  modport master (
    input  instr, mem_rdy, zflag,
    output ir_ld, pc_inc, pc_ld, mem_rd, mem_wr, alu_op, w_sel,
           W_Adr, we, R_Adr, S_Adr, halted, illegal
  );
  modport slave (
    output instr, mem_rdy, zflag,
    input  ir_ld, pc_inc, pc_ld, mem_rd, mem_wr, alu_op, w_sel,
           W_Adr, we, R_Adr, S_Adr, halted, illegal
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational IR decode: instruction class, ALU function and register addresses.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [CTRL_OP_W-1:0]  i_op,
  input  logic [8:0]            i_fld,
  output iclass_t               o_cls,
  output logic [CTRL_OP_W-1:0]  o_alu_op,
  output logic [CTRL_ADR_W-1:0] o_w_adr,
  output logic [CTRL_ADR_W-1:0] o_r_adr,
  output logic [CTRL_ADR_W-1:0] o_s_adr
);
  always_comb begin
    o_cls    = CL_ILL;
    o_alu_op = ALU_NONE;
    case (i_op)
      OP_NOP: o_cls = CL_NOP;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV, OP_INC: begin
        o_cls    = CL_ALU;
        o_alu_op = i_op;
      end
      OP_LD:   o_cls = CL_LD;
      OP_ST:   o_cls = CL_ST;
      OP_BRZ:  o_cls = CL_BRZ;
      OP_HLT:  o_cls = CL_HLT;
      default: o_cls = CL_ILL;
    endcase
  end

  assign o_w_adr = i_fld[IR_W_LSB +: CTRL_ADR_W];
  assign o_r_adr = i_fld[IR_R_LSB +: CTRL_ADR_W];
  assign o_s_adr = i_fld[IR_S_LSB +: CTRL_ADR_W];
endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/HALT sequencer holding the IR.
// Define CTRL_ILLEGAL_TRAP_EN to trap opcodes B-E into HALT with illegal raised.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int DATA_W = CTRL_DATA_W,
  parameter int ADR_W  = CTRL_ADR_W,
  parameter int OP_W   = CTRL_OP_W
) (
  input logic                 clk,
  input logic                 reset,
  control_sequencer_if.master bus
);
  state_t            r_state, w_next;
  logic [DATA_W-1:0] r_ir;
  iclass_t           w_cls;
  logic [OP_W-1:0]   w_alu_op;
  logic [ADR_W-1:0]  w_w_adr, w_r_adr, w_s_adr;
  logic              w_ir_ld, w_pc_inc, w_pc_ld, w_mem_rd, w_mem_wr, w_we, w_w_sel;
  logic              w_unused_ir;

  assign w_unused_ir = ^r_ir[11:9];

  ctrl_decode u_dec (
    .i_op     (r_ir[IR_OP_LSB +: OP_W]),
    .i_fld    (r_ir[8:0]),
    .o_cls    (w_cls),
    .o_alu_op (w_alu_op),
    .o_w_adr  (w_w_adr),
    .o_r_adr  (w_r_adr),
    .o_s_adr  (w_s_adr)
  );

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic r_illegal, w_set_ill;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_illegal <= 1'b0;
    else if (w_set_ill) r_illegal <= 1'b1;
  end
  assign bus.illegal = r_illegal;
`else
  assign bus.illegal = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (w_ir_ld) r_ir <= bus.instr;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_ir_ld  = 1'b0;
    w_pc_inc = 1'b0;
    w_pc_ld  = 1'b0;
    w_mem_rd = 1'b0;
    w_mem_wr = 1'b0;
    w_we     = 1'b0;
    w_w_sel  = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    w_set_ill = 1'b0;
`endif
    case (r_state)
      S_FETCH: begin
        w_mem_rd = 1'b1;
        if (bus.mem_rdy) begin
          w_ir_ld = 1'b1;
          w_next  = S_DECODE;
        end
      end
      S_DECODE: begin
        w_pc_inc = 1'b1;
        case (w_cls)
          CL_ALU, CL_BRZ: w_next = S_EXEC;
          CL_LD, CL_ST:   w_next = S_MEM;
          CL_HLT:         w_next = S_HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
          CL_ILL: begin
            w_next    = S_HALT;
            w_set_ill = 1'b1;
          end
`endif
          default:        w_next = S_FETCH;
        endcase
      end
      S_EXEC: begin
        w_we    = (w_cls == CL_ALU);
        w_pc_ld = (w_cls == CL_BRZ) && bus.zflag;
        w_next  = S_FETCH;
      end
      S_MEM: begin
        // load write-back lands in the ready cycle, so we and mem_wr never overlap
        w_mem_rd = (w_cls == CL_LD);
        w_mem_wr = (w_cls == CL_ST);
        w_we     = (w_cls == CL_LD) && bus.mem_rdy;
        w_w_sel  = (w_cls == CL_LD) && bus.mem_rdy;
        if (bus.mem_rdy) w_next = S_FETCH;
      end
      default: w_next = S_HALT;
    endcase
  end

  // strobes are gated by reset so they drop the instant reset rises
  assign bus.ir_ld  = w_ir_ld  & ~reset;
  assign bus.pc_inc = w_pc_inc & ~reset;
  assign bus.pc_ld  = w_pc_ld  & ~reset;
  assign bus.mem_rd = w_mem_rd & ~reset;
  assign bus.mem_wr = w_mem_wr & ~reset;
  assign bus.we     = w_we     & ~reset;
  assign bus.w_sel  = w_w_sel  & ~reset;
  assign bus.alu_op = w_alu_op;
  assign bus.W_Adr  = w_w_adr;
  assign bus.R_Adr  = w_r_adr;
  assign bus.S_Adr  = w_s_adr;
  assign bus.halted = (r_state == S_HALT);
endmodule

// File: tb/tb_control_sequencer.sv
// Randomized + directed bench for control_sequencer against an instruction-level model.
module tb_control_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  control_sequencer_if bus();
  control_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int pc_inc_cnt = 0;

  // model: instruction in hand and how far through it we are (0 fetch, 1 decode, 2 execute/access)
  logic [15:0] m_ir = 16'h0;
  int          m_step = 0;
  bit          m_halt = 1'b0;
  bit          m_ill = 1'b0;

  // 0 nop, 1 alu, 2 ld, 3 st, 4 brz, 5 hlt, 6 undefined
  function automatic int kind(input logic [15:0] ir);
    int op;
    op = int'(ir[15:12]);
    if (op == 0) return 0;
    if (op <= 7) return 1;
    if (op == 8) return 2;
    if (op == 9) return 3;
    if (op == 10) return 4;
    if (op == 15) return 5;
    return 6;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ir = 16'h0; m_step = 0; m_halt = 1'b0; m_ill = 1'b0;
  endtask

  task automatic model_update();
    int k;
    k = kind(m_ir);
    if (reset) model_reset();
    else if (!m_halt) begin
      if (m_step == 0) begin
        if (bus.mem_rdy) begin m_ir = bus.instr; m_step = 1; end
      end else if (m_step == 1) begin
        if (k == 1 || k == 2 || k == 3 || k == 4) m_step = 2;
        else if (k == 5) m_halt = 1'b1;
        else if (k == 6) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          m_halt = 1'b1; m_ill = 1'b1;
`else
          m_step = 0;
`endif
        end else m_step = 0;
      end else begin
        if (k == 1 || k == 4 || bus.mem_rdy) m_step = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    logic e_ir_ld, e_pc_inc, e_pc_ld, e_rd, e_wr, e_we, e_wsel;
    int k, op;
    k = kind(m_ir);
    op = int'(m_ir[15:12]);
    e_ir_ld = 0; e_pc_inc = 0; e_pc_ld = 0; e_rd = 0; e_wr = 0; e_we = 0; e_wsel = 0;
    if (!reset && !m_halt) begin
      if (m_step == 0) begin e_rd = 1; e_ir_ld = bus.mem_rdy; end
      else if (m_step == 1) e_pc_inc = 1;
      else begin
        e_we    = (k == 1) || (k == 2 && bus.mem_rdy);
        e_wsel  = (k == 2 && bus.mem_rdy);
        e_pc_ld = (k == 4) && bus.zflag;
        e_rd    = (k == 2);
        e_wr    = (k == 3);
      end
    end
    if (bus.pc_inc) pc_inc_cnt++;
    chk("ir_ld", 32'(bus.ir_ld), 32'(e_ir_ld));
    chk("pc_inc", 32'(bus.pc_inc), 32'(e_pc_inc));
    chk("pc_ld", 32'(bus.pc_ld), 32'(e_pc_ld));
    chk("mem_rd", 32'(bus.mem_rd), 32'(e_rd));
    chk("mem_wr", 32'(bus.mem_wr), 32'(e_wr));
    chk("we", 32'(bus.we), 32'(e_we));
    chk("w_sel", 32'(bus.w_sel), 32'(e_wsel));
    chk("alu_op", 32'(bus.alu_op), (op >= 1 && op <= 7) ? 32'(op) : 32'd0);
    chk("W_Adr", 32'(bus.W_Adr), 32'(m_ir[8:6]));
    chk("R_Adr", 32'(bus.R_Adr), 32'(m_ir[5:3]));
    chk("S_Adr", 32'(bus.S_Adr), 32'(m_ir[2:0]));
    chk("halted", 32'(bus.halted), 32'(m_halt));
    chk("illegal", 32'(bus.illegal), 32'(m_ill));
  end

  task automatic drive(input logic [15:0] i, input logic r, input logic z);
    bus.instr = i; bus.mem_rdy = r; bus.zflag = z;
  endtask

  task automatic tick();
    @(posedge clk); #1; model_update();
  endtask

  task automatic pulse_reset();
    reset = 1'b1; model_reset(); tick(); reset = 1'b0;
  endtask

  initial begin
    int p0;
    logic [15:0] ins;
    logic [3:0] op;
    drive(16'h0, 1'b0, 1'b0);
    model_reset();
    tick();
    chk("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_alu_op", 32'(bus.alu_op), 32'd0);
    chk("rst_W_Adr", 32'(bus.W_Adr), 32'd0);
    reset = 1'b0;

    // ADD r1 = r2 + r3
    p0 = pc_inc_cnt;
    drive(16'h1053, 1, 0); #1 chk("add_ir_ld", 32'(bus.ir_ld), 32'd1); tick();
    drive(16'h0, 1, 0); #1 chk("add_pc_inc", 32'(bus.pc_inc), 32'd1); tick();
    drive(16'h0, 1, 0); #1;
    chk("add_we", 32'(bus.we), 32'd1);
    chk("add_W", 32'(bus.W_Adr), 32'd1);
    chk("add_R", 32'(bus.R_Adr), 32'd2);
    chk("add_S", 32'(bus.S_Adr), 32'd3);
    chk("add_alu", 32'(bus.alu_op), 32'd1);
    chk("add_wsel", 32'(bus.w_sel), 32'd0);
    tick();
    chk("add_pc_inc_total", 32'(pc_inc_cnt - p0), 32'd1);

    // LD r4 = mem[r5] with a slow memory
    drive(16'h8128, 1, 0); tick();
    drive(16'h0, 1, 0); tick();
    repeat (3) begin
      drive(16'h0, 0, 0); #1;
      chk("ld_wait_rd", 32'(bus.mem_rd), 32'd1);
      chk("ld_wait_we", 32'(bus.we), 32'd0);
      tick();
    end
    drive(16'h0, 1, 0); #1;
    chk("ld_we", 32'(bus.we), 32'd1);
    chk("ld_wsel", 32'(bus.w_sel), 32'd1);
    chk("ld_W", 32'(bus.W_Adr), 32'd4);
    chk("ld_R", 32'(bus.R_Adr), 32'd5);
    tick();

    // ST
    drive(16'h9009, 1, 0); tick();
    drive(16'h0, 1, 0); tick();
    repeat (2) begin
      drive(16'h0, 0, 0); #1;
      chk("st_wr", 32'(bus.mem_wr), 32'd1);
      chk("st_we", 32'(bus.we), 32'd0);
      tick();
    end
    drive(16'h0, 1, 0); #1 chk("st_wr_rdy", 32'(bus.mem_wr), 32'd1); tick();

    // BRZ taken and not taken
    for (int z = 1; z >= 0; z--) begin
      drive(16'hA1FE, 1, 0); tick();
      drive(16'h0, 1, 0); tick();
      drive(16'h0, 1, 1'(z)); #1 chk("brz_pc_ld", 32'(bus.pc_ld), 32'(z)); tick();
    end

    // undefined opcode
    drive(16'hB000, 1, 0); tick();
    drive(16'h0, 1, 0); #1 chk("undef_pc_inc", 32'(bus.pc_inc), 32'd1); tick();
    drive(16'h0, 0, 0); #1;
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("undef_halted", 32'(bus.halted), 32'd1);
    chk("undef_illegal", 32'(bus.illegal), 32'd1);
    tick();
    pulse_reset();
`else
    chk("undef_halted", 32'(bus.halted), 32'd0);
    chk("undef_fetch", 32'(bus.mem_rd), 32'd1);
    tick();
`endif

    // reset in the middle of a load
    drive(16'h8050, 1, 0); tick();
    drive(16'h0, 1, 0); tick();
    drive(16'h0, 0, 0); #1 chk("ldrst_rd", 32'(bus.mem_rd), 32'd1);
    #1 reset = 1'b1; model_reset();
    #1;
    chk("ldrst_rd_drop", 32'(bus.mem_rd), 32'd0);
    chk("ldrst_we", 32'(bus.we), 32'd0);
    chk("ldrst_halted", 32'(bus.halted), 32'd0);
    drive(16'h0, 1, 0); #1 chk("ldrst_ir_ld", 32'(bus.ir_ld), 32'd0);
    tick();
    reset = 1'b0;
    drive(16'h0, 0, 0); #1 chk("ldrst_fetch", 32'(bus.mem_rd), 32'd1); tick();

    // HLT
    drive(16'hF000, 1, 0); tick();
    drive(16'h0, 1, 0); tick();
    repeat (5) begin
      drive(16'($urandom), 1, 1'($urandom)); #1;
      chk("hlt_halted", 32'(bus.halted), 32'd1);
      chk("hlt_rd", 32'(bus.mem_rd), 32'd0);
      tick();
    end
    pulse_reset();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (m_halt && ($urandom % 4 == 0)) begin
        pulse_reset();
        continue;
      end
      op = 4'($urandom);
      if ((op == 4'hF || (op >= 4'hB && op <= 4'hE)) && ($urandom % 4 != 0)) op = 4'h1;
      ins = {op, 12'($urandom)};
      drive(ins, ($urandom % 4) != 0, 1'($urandom));
      if ($urandom % 60 == 0) begin
        #1 reset = 1'b1; model_reset();
        tick();
        reset = 1'b0;
      end else tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
